dither_pixel_packer: RTL and testbench

Upstream feeder for the blue-noise dithering stage. Accepts one 8-bit grayscale pixel per clock from the video input path, packs four consecutive pixels into a 32-bit word (leftmost pixel in bits [31:24]), and generates the noise-tile coordinates: `x_pos` is the word index within the line modulo 16, and `y_pos` is the line index modulo 64. It tracks frame/line boundaries, flags lines that are not a multiple of four pixels, and optionally offsets coordinates per frame for temporal dithering.

---
 rtl/dither_pkg.sv | 22 ++
 rtl/dither_word_packer.sv | 61 ++++++
 rtl/dither_pixel_packer.sv | 130 +++++++++++++
 tb/tb_dither_pixel_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// ---------------------------------------------------------------------------
// dither_pkg
// Shared constants for the blue-noise dither feeder: default noise-tile
// dimensions, pixel/word geometry and the per-frame vertical offset
// multiplier used when temporal dithering (TEMPORAL_DITHER_EN) is built.
// ---------------------------------------------------------------------------
package dither_pkg;

    // Default noise tile: 16 words wide, 64 lines tall
    localparam int X_BITS_DEF   = 4;
    localparam int Y_BITS_DEF   = 6;

    // Pixel and packed-word geometry
    localparam int PIX_BITS     = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_BITS    = PIX_BITS * PIX_PER_WORD;
    localparam int PHASE_BITS   = $clog2(PIX_PER_WORD);

    // Vertical noise offset advances this many lines per frame
    localparam int FC_Y_MUL     = 3;

endpackage

// File: rtl/dither_word_packer.sv
// ---------------------------------------------------------------------------
// dither_word_packer
// Collects four consecutive 8-bit pixels into one 32-bit word, leftmost
// pixel in the top byte. A clear in the same cycle as a pixel restarts the
// word so that pixel becomes slot 0.
// Ports:
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_clr           discard any held pixels (line/frame boundary)
//   i_pix_valid     i_pix carries a pixel this cycle
//   i_pix           grayscale pixel
//   o_word          assembled word, valid while o_word_done is high
//   o_word_done     this cycle's pixel completes a word (combinational)
//   o_partial       pixels are currently held (phase != 0)
// ---------------------------------------------------------------------------
module dither_word_packer
    import dither_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clr,
    input  logic                  i_pix_valid,
    input  logic [PIX_BITS-1:0]   i_pix,
    output logic [WORD_BITS-1:0]  o_word,
    output logic                  o_word_done,
    output logic                  o_partial
);

    logic [PHASE_BITS-1:0] r_phase;
    logic [PHASE_BITS-1:0] w_phase;
    logic [PIX_BITS-1:0]   r_pix0;
    logic [PIX_BITS-1:0]   r_pix1;
    logic [PIX_BITS-1:0]   r_pix2;

    // A boundary takes effect before the pixel of the same cycle
    assign w_phase     = i_clr ? '0 : r_phase;
    assign o_word_done = i_pix_valid && (w_phase == PHASE_BITS'(PIX_PER_WORD - 1));
    assign o_word      = {r_pix0, r_pix1, r_pix2, i_pix};
    assign o_partial   = (r_phase != '0);

    // Store the pixel at its slot; the fourth pixel is consumed directly
    // from i_pix, so only slots 0..2 need storage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_phase <= '0;
            r_pix0  <= '0;
            r_pix1  <= '0;
            r_pix2  <= '0;
        end else if (i_pix_valid) begin
            r_phase <= o_word_done ? '0 : w_phase + PHASE_BITS'(1);
            case (w_phase)
                PHASE_BITS'(0): r_pix0 <= i_pix;
                PHASE_BITS'(1): r_pix1 <= i_pix;
                PHASE_BITS'(2): r_pix2 <= i_pix;
                default: ;
            endcase
        end else if (i_clr) begin
            r_phase <= '0;
        end
    end

endmodule

// File: rtl/dither_pixel_packer.sv
// ---------------------------------------------------------------------------
// dither_pixel_packer
// Upstream feeder for the blue-noise dither stage. Packs 4 pixels per word
// and tags each word with its noise-tile coordinates (word index within the
// line, line index within the frame). Flags lines/frames that end with a
// partial word.
// Optional feature: define TEMPORAL_DITHER_EN to offset the coordinates by
// a per-frame counter (x + fc, y + 3*fc) so the noise moves every frame.
// Ports:
//   i_clk, i_rstn      clock, asynchronous active-low reset
//   i_frame_start      frame boundary pulse (wins over i_line_start)
//   i_line_start       line boundary pulse
//   i_pix_valid, i_pix pixel input
//   o_vout             packed word, pixel 0 in [31:24]
//   o_vout_valid       one-cycle pulse per word
//   o_x_pos, o_y_pos   noise column/row for o_vout
//   o_align_err        sticky partial-word flag
//   i_err_clr          clears o_align_err (a simultaneous set wins)
// ---------------------------------------------------------------------------
module dither_pixel_packer
    import dither_pkg::*;
#(
    parameter int X_BITS = X_BITS_DEF,
    parameter int Y_BITS = Y_BITS_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_frame_start,
    input  logic                  i_line_start,
    input  logic                  i_pix_valid,
    input  logic [PIX_BITS-1:0]   i_pix,
    input  logic                  i_err_clr,
    output logic [WORD_BITS-1:0]  o_vout,
    output logic                  o_vout_valid,
    output logic [X_BITS-1:0]     o_x_pos,
    output logic [Y_BITS-1:0]     o_y_pos,
    output logic                  o_align_err
);

    logic                 w_boundary;
    logic [WORD_BITS-1:0] w_word;
    logic                 w_word_done;
    logic                 w_partial;
    logic [X_BITS-1:0]    w_x_pos;
    logic [Y_BITS-1:0]    w_y_pos;
    logic [X_BITS-1:0]    r_xw;
    logic [Y_BITS-1:0]    r_yl;

    assign w_boundary = i_frame_start | i_line_start;

    dither_word_packer u_packer (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_clr       (w_boundary),
        .i_pix_valid (i_pix_valid),
        .i_pix       (i_pix),
        .o_word      (w_word),
        .o_word_done (w_word_done),
        .o_partial   (w_partial)
    );

`ifdef TEMPORAL_DITHER_EN
    logic [3:0] r_fc;

    // Frame counter shifts the noise tile every frame
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fc <= '0;
        end else if (i_frame_start) begin
            r_fc <= r_fc + 4'd1;
        end
    end

    assign w_x_pos = r_xw + X_BITS'(r_fc);
    assign w_y_pos = r_yl + Y_BITS'(FC_Y_MUL * r_fc);
`else
    assign w_x_pos = r_xw;
    assign w_y_pos = r_yl;
`endif

    // Word/line counters. A completed word can never coincide with a
    // boundary (the boundary forces the pixel into slot 0), so the boundary
    // clear and the word increment are mutually exclusive.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_xw <= '0;
            r_yl <= '0;
        end else begin
            if (w_boundary) begin
                r_xw <= '0;
            end else if (w_word_done) begin
                r_xw <= r_xw + X_BITS'(1);
            end
            if (i_frame_start) begin
                r_yl <= '0;
            end else if (i_line_start) begin
                r_yl <= r_yl + Y_BITS'(1);
            end
        end
    end

    // Output register: word and coordinates hold between pulses
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_vout       <= '0;
            o_vout_valid <= 1'b0;
            o_x_pos      <= '0;
            o_y_pos      <= '0;
        end else begin
            o_vout_valid <= w_word_done;
            if (w_word_done) begin
                o_vout  <= w_word;
                o_x_pos <= w_x_pos;
                o_y_pos <= w_y_pos;
            end
        end
    end

    // Sticky alignment error: set on a boundary that drops held pixels
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_align_err <= 1'b0;
        end else if (w_boundary && w_partial) begin
            o_align_err <= 1'b1;
        end else if (i_err_clr) begin
            o_align_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dither_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_dither_pixel_packer
// Directed test of dither_pixel_packer with hand-computed expected words and
// coordinates. Coordinates are predicted from word/line indices plus the
// frame count when TEMPORAL_DITHER_EN is defined.
// ---------------------------------------------------------------------------
module tb_dither_pixel_packer;

    logic        clk;
    logic        rstn;
    logic        frameStart;
    logic        lineStart;
    logic        pixValid;
    logic [7:0]  pix;
    logic        errClr;
    logic [31:0] vout;
    logic        voutValid;
    logic [3:0]  xPos;
    logic [5:0]  yPos;
    logic        alignErr;

    int assertCount = 0;
    int failCount   = 0;
    int expFc       = 0;
    int pulses;
    logic [31:0] lastWord;
    logic [3:0]  lastX;

    dither_pixel_packer dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_frame_start (frameStart),
        .i_line_start  (lineStart),
        .i_pix_valid   (pixValid),
        .i_pix         (pix),
        .i_err_clr     (errClr),
        .o_vout        (vout),
        .o_vout_valid  (voutValid),
        .o_x_pos       (xPos),
        .o_y_pos       (yPos),
        .o_align_err   (alignErr)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected noise column for word index xw
    function automatic logic [3:0] ex(input int xw);
`ifdef TEMPORAL_DITHER_EN
        ex = 4'((xw + expFc) % 16);
`else
        ex = 4'(xw % 16);
`endif
    endfunction

    // Expected noise row for line index yl
    function automatic logic [5:0] ey(input int yl);
`ifdef TEMPORAL_DITHER_EN
        ey = 6'((yl + 3 * expFc) % 64);
`else
        ey = 6'(yl % 64);
`endif
    endfunction

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one clock of inputs, sample 1 ns after the rising edge
    task automatic applyStimulus(input logic fs, input logic ls, input logic pv,
                                 input logic [7:0] p, input logic clr);
        frameStart = fs;
        lineStart  = ls;
        pixValid   = pv;
        pix        = p;
        errClr     = clr;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
        lineStart  = 1'b0;
        pixValid   = 1'b0;
        pix        = 8'h00;
        errClr     = 1'b0;
        if (fs) expFc = (expFc + 1) % 16;
    endtask

    // Push a word of four pixels base..base+3, optionally with a boundary on the first
    task automatic pushWord(input logic [7:0] base, input logic fs, input logic ls);
        applyStimulus(fs, ls, 1'b1, base, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, base + 8'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, base + 8'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, base + 8'd3, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        frameStart = 1'b0; lineStart = 1'b0; pixValid = 1'b0;
        pix = 8'h00; errClr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_vout",  vout, 32'h0);
        checkOutput("rst_valid", {31'b0, voutValid}, 32'h0);
        checkOutput("rst_x",     {28'b0, xPos}, 32'h0);
        checkOutput("rst_y",     {26'b0, yPos}, 32'h0);
        checkOutput("rst_err",   {31'b0, alignErr}, 32'h0);
        rstn = 1'b1;

        // Two words after a frame start
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 1'b0);
        checkOutput("w0_early", {31'b0, voutValid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        checkOutput("w0_valid", {31'b0, voutValid}, 32'h1);
        checkOutput("w0_vout",  vout, 32'h01020304);
        checkOutput("w0_x",     {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("w0_y",     {26'b0, yPos}, {26'b0, ey(0)});
        pushWord(8'h05, 1'b0, 1'b0);
        checkOutput("w1_valid", {31'b0, voutValid}, 32'h1);
        checkOutput("w1_vout",  vout, 32'h05060708);
        checkOutput("w1_x",     {28'b0, xPos}, {28'b0, ex(1)});
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("w1_pulse", {31'b0, voutValid}, 32'h0);
        checkOutput("w1_hold",  vout, 32'h05060708);

        // 68 contiguous pixels: 17 words, the last one wraps x to 0
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        pulses = 0;
        for (int i = 0; i < 68; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
            if (voutValid) begin
                pulses++;
                lastWord = vout;
                lastX    = xPos;
            end
        end
        checkOutput("wrap_count", 32'(pulses), 32'd17);
        checkOutput("wrap_word",  lastWord, 32'h40414243);
        checkOutput("wrap_x",     {28'b0, lastX}, {28'b0, ex(16)});
        pushWord(8'h10, 1'b0, 1'b1);
        checkOutput("l1_vout", vout, 32'h10111213);
        checkOutput("l1_x",    {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("l1_y",    {26'b0, yPos}, {26'b0, ey(1)});

        // Line counter wrap and frame/line priority
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        pushWord(8'h30, 1'b0, 1'b0);
        checkOutput("y63", {26'b0, yPos}, {26'b0, ey(63)});
        pushWord(8'h34, 1'b0, 1'b1);
        checkOutput("y64_wrap", {26'b0, yPos}, {26'b0, ey(64)});
        pushWord(8'h38, 1'b1, 1'b1);
        checkOutput("fs_ls_y",    {26'b0, yPos}, {26'b0, ey(0)});
        checkOutput("fs_ls_x",    {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("fs_ls_vout", vout, 32'h38393a3b);

        // Partial word dropped at a line boundary
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("err_init", {31'b0, alignErr}, 32'h0);
        pushWord(8'h21, 1'b0, 1'b0);
        checkOutput("pw_vout", vout, 32'h21222324);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h25, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h26, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("pw_novalid", {31'b0, voutValid}, 32'h0);
        checkOutput("pw_err",     {31'b0, alignErr}, 32'h1);
        pushWord(8'h50, 1'b0, 1'b0);
        checkOutput("pw_next_vout", vout, 32'h50515253);
        checkOutput("pw_next_x",    {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("pw_next_y",    {26'b0, yPos}, {26'b0, ey(1)});
        checkOutput("pw_sticky",    {31'b0, alignErr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("pw_clr", {31'b0, alignErr}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h60, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h61, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("set_wins", {31'b0, alignErr}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("clr2", {31'b0, alignErr}, 32'h0);

        // Sixteen frame starts return the frame counter to the same value
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        pushWord(8'h70, 1'b0, 1'b0);
        checkOutput("fc16_x", {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("fc16_y", {26'b0, yPos}, {26'b0, ey(0)});

        // Reset mid-word with gapped pixels: outputs clear without a clock
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h82, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("arst_vout",  vout, 32'h0);
        checkOutput("arst_valid", {31'b0, voutValid}, 32'h0);
        checkOutput("arst_x",     {28'b0, xPos}, 32'h0);
        checkOutput("arst_y",     {26'b0, yPos}, 32'h0);
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        expFc = 0;
        pushWord(8'h90, 1'b0, 1'b0);
        checkOutput("post_rst_valid", {31'b0, voutValid}, 32'h1);
        checkOutput("post_rst_vout",  vout, 32'h90919293);
        checkOutput("post_rst_x",     {28'b0, xPos}, 32'h0);
        checkOutput("post_rst_y",     {26'b0, yPos}, 32'h0);
        checkOutput("post_rst_err",   {31'b0, alignErr}, 32'h0);

        // Two frames after reset: temporal offset of fc=2 when enabled
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        pushWord(8'ha0, 1'b0, 1'b0);
        checkOutput("fc2_x", {28'b0, xPos}, {28'b0, ex(0)});
        checkOutput("fc2_y", {26'b0, yPos}, {26'b0, ey(0)});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
